// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: receive-side sequencer for one 802.15.4 PPDU at a time.
// Enables the demod/CDR chain, hunts preamble + SFD, parses the PHR and
// hands PSDU bytes to the MAC through a 2-entry valid/ready buffer.
// Optional FCS check (CRC-16/ITU-T, reflected) is built when RX_SEQ_CRC_EN
// is defined; otherwise crc_ok is tied high.
//
// state     | meaning
// IDLE      | chain disabled, waiting for rx_en
// WAIT_LOCK | demod enabled, waiting for CDR lock
// HUNT      | counting preamble zeros, matching the SFD window
// PHR       | collecting the length byte
// PAYLOAD   | collecting PSDU bytes into the buffer
// DRAIN     | all bytes received, waiting for the MAC to take the rest
module rx_frame_sequencer #(
  parameter int         PREAMBLE_MIN_BITS = 8,
  parameter logic [7:0] SFD_PATTERN       = 8'hA7,
  parameter int         MAX_LEN           = 127,
  parameter int         TIMEOUT_CYCLES    = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_en,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       cdr_lock,
  output logic       demod_en,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_last,
  output logic [6:0] frame_len,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       crc_ok,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, WAIT_LOCK, HUNT, PHR, PAYLOAD, DRAIN} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef RX_SEQ_CRC_EN
  localparam logic [7:0] MIN_L8 = 8'd3;   // two FCS bytes plus at least one data byte
`else
  localparam logic [7:0] MIN_L8 = 8'd1;
`endif
  localparam logic [7:0] MAX_L8 = 8'(MAX_LEN);
  localparam logic [7:0] ZR_MIN = 8'(PREAMBLE_MIN_BITS);

  localparam logic [2:0] ERR_NONE = 3'd0, ERR_LEN = 3'd1, ERR_OVF = 3'd2,
                         ERR_LOCK = 3'd3, ERR_TMO = 3'd4;

  state_t          state, state_next;
  logic [7:0]      sr, sr_new, zero_run;
  logic            armed;
  logic [2:0]      bitcnt;
  logic [6:0]      byte_cnt;
  logic [TW-1:0]   tmr;
  logic [8:0]      fifo_mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      fifo_cnt;
  logic            shift_en, byte_done, push, push_last, pop, ovf, tmo, sfd_hit, len_bad;
  logic [2:0]      err_set;
  logic            start_set, done_set, flush;

  assign sr_new     = {bit_in, sr[7:1]};
  assign shift_en   = bit_valid && (state == HUNT || state == PHR || state == PAYLOAD);
  assign byte_done  = bit_valid && (bitcnt == 3'd7);
  assign sfd_hit    = bit_valid && armed && (bitcnt == 3'd7) && (sr_new == SFD_PATTERN);
  assign len_bad    = ({1'b0, sr_new[6:0]} < MIN_L8) || ({1'b0, sr_new[6:0]} > MAX_L8);
  assign push       = (state == PAYLOAD) && byte_done && cdr_lock;
  assign push_last  = ({1'b0, byte_cnt} + 8'd1) == {1'b0, frame_len};
  assign pop        = byte_valid && byte_ready;
  assign ovf        = push && (fifo_cnt == 2'd2) && !pop;
  // The idle timer only guards bit reception; a stalled MAC in DRAIN is not a timeout.
  assign tmo        = (state == PHR || state == PAYLOAD) && !bit_valid && (tmr == '0);

  assign byte_valid = (fifo_cnt != 2'd0);
  assign byte_data  = fifo_mem[rd_ptr][7:0];
  assign byte_last  = fifo_mem[rd_ptr][8];
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state, event and error decisions; lock loss outranks overflow outranks timeout.
  always_comb begin
    state_next = state;
    err_set    = ERR_NONE;
    start_set  = 1'b0;
    done_set   = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE:      if (rx_en) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (!rx_en)        state_next = IDLE;
        else if (cdr_lock) state_next = HUNT;
      end
      HUNT: begin
        if (!rx_en)         state_next = IDLE;
        else if (!cdr_lock) state_next = WAIT_LOCK;
        else if (sfd_hit)   state_next = PHR;
      end
      PHR: begin
        if (!cdr_lock) begin
          err_set = ERR_LOCK; state_next = WAIT_LOCK;
        end else if (tmo) begin
          err_set = ERR_TMO; state_next = HUNT;
        end else if (byte_done) begin
          if (len_bad) begin
            err_set = ERR_LEN; state_next = HUNT;
          end else begin
            start_set = 1'b1; state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!cdr_lock) begin
          err_set = ERR_LOCK; flush = 1'b1; state_next = WAIT_LOCK;
        end else if (ovf) begin
          err_set = ERR_OVF; flush = 1'b1; state_next = HUNT;
        end else if (tmo) begin
          err_set = ERR_TMO; flush = 1'b1; state_next = HUNT;
        end else if (push && push_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!cdr_lock) begin
          err_set = ERR_LOCK; flush = 1'b1; state_next = WAIT_LOCK;
        end else if (pop && fifo_cnt == 2'd1) begin
          done_set   = 1'b1;
          state_next = rx_en ? HUNT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered status outputs and event pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      demod_en <= 1'b0; frame_start <= 1'b0; frame_done <= 1'b0; frame_err <= 1'b0;
      err_code <= ERR_NONE; frame_len <= 7'd0;
    end else begin
      demod_en    <= (state_next != IDLE);
      frame_start <= start_set;
      frame_done  <= done_set;
      frame_err   <= (err_set != ERR_NONE);
      if (err_set != ERR_NONE) err_code <= err_set;
      else if (start_set)      err_code <= ERR_NONE;
      if (start_set) frame_len <= sr_new[6:0];
    end
  end

  // Bit shifter, preamble/SFD hunt and bit/byte counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr <= 8'd0; zero_run <= 8'd0; armed <= 1'b0; bitcnt <= 3'd0; byte_cnt <= 7'd0;
    end else begin
      if (shift_en) sr <= sr_new;
      if (start_set)  byte_cnt <= 7'd0;
      else if (push)  byte_cnt <= byte_cnt + 7'd1;
      if (state_next != state) begin
        zero_run <= 8'd0; armed <= 1'b0; bitcnt <= 3'd0;
      end else if (bit_valid) begin
        case (state)
          HUNT: begin
            zero_run <= bit_in ? 8'd0 : ((zero_run == 8'hFF) ? zero_run : zero_run + 8'd1);
            // Bits inside a failed SFD window never arm a new one.
            if (armed) begin
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) armed <= 1'b0;
            end else if (bit_in && zero_run >= ZR_MIN) begin
              armed <= 1'b1; bitcnt <= 3'd1;
            end
          end
          PHR, PAYLOAD: bitcnt <= bitcnt + 3'd1;
          default: ;
        endcase
      end
    end
  end

  // Idle down-counter: reloaded on entry to PHR/PAYLOAD and on every bit.
  always_ff @(posedge clk) begin
    if (!reset_n) tmr <= '0;
    else if ((state_next == PHR || state_next == PAYLOAD) && (state_next != state || bit_valid))
      tmr <= TW'(TIMEOUT_CYCLES - 1);
    else if (tmr != '0)
      tmr <= tmr - 1'b1;
  end

  // Two-entry byte buffer; simultaneous push and pop are both honoured when full.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fifo_mem[0] <= 9'd0; fifo_mem[1] <= 9'd0;
      wr_ptr <= 1'b0; rd_ptr <= 1'b0; fifo_cnt <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0; rd_ptr <= 1'b0; fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {push_last, sr_new};
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef RX_SEQ_CRC_EN
  logic [15:0] crc, crc_nx;
  assign crc_nx = {1'b0, crc[15:1]} ^ ((crc[0] ^ bit_in) ? 16'h8408 : 16'h0000);

  // FCS accumulator over every PSDU bit; a correct FCS leaves a zero remainder.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc <= 16'd0; crc_ok <= 1'b1;
    end else begin
      if (start_set) crc <= 16'd0;
      else if (state == PAYLOAD && bit_valid && cdr_lock) crc <= crc_nx;
      if (push && push_last) crc_ok <= (crc_nx == 16'd0);
    end
  end
`else
  assign crc_ok = 1'b1;
`endif

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Self-checking bench for rx_frame_sequencer: directed frames plus randomized
// streams checked against a frame-level reference model.
module tb_rx_frame_sequencer;
  localparam int TMO = 400;
`ifdef RX_SEQ_CRC_EN
  localparam int MIN_LEN = 3;
`else
  localparam int MIN_LEN = 1;
`endif

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0, reset_n = 1'b0, rx_en = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
  logic cdr_lock = 1'b0, byte_ready = 1'b0, rdy_rand = 1'b0;
  logic demod_en, byte_valid, byte_last, frame_start, frame_done, frame_err, crc_ok, busy;
  logic [7:0] byte_data;
  logic [6:0] frame_len;
  logic [2:0] err_code;

  int n_cmp = 0, n_bad = 0;
  int n_start = 0, n_done = 0, n_err = 0;
  int s0 = 0, d0 = 0, e0 = 0;
  int gap_lo = 5, gap_hi = 5;
  logic [8:0] rx_q[$];
  logic stall_prev = 1'b0;
  logic [8:0] stall_word = 9'd0;

  always #5 clk = ~clk;

  rx_frame_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .bit_valid(bit_valid), .bit_in(bit_in),
    .cdr_lock(cdr_lock), .demod_en(demod_en), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_last(byte_last), .frame_len(frame_len),
    .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .crc_ok(crc_ok), .busy(busy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random MAC back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) byte_ready = ($urandom_range(0, 1) == 1);
  end

  // Event counters, accepted-byte log and hold-stability check.
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_start) n_start++;
      if (frame_done)  n_done++;
      if (frame_err)   n_err++;
      if (byte_valid && stall_prev) check("hold", {23'd0, byte_last, byte_data}, {23'd0, stall_word});
      if (byte_valid && byte_ready) rx_q.push_back({byte_last, byte_data});
      stall_prev = byte_valid && !byte_ready;
      stall_word = {byte_last, byte_data};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic send_bit(input logic b);
    int g;
    g = $urandom_range(gap_lo, gap_hi);
    bit_in = b; bit_valid = 1'b1; tick(); bit_valid = 1'b0;
    repeat (g - 1) tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_zeros(input int n); repeat (n) send_bit(1'b0); endtask
  task automatic send_ones(input int n);  repeat (n) send_bit(1'b1); endtask

  task automatic send_frame(input int pre, input logic [7:0] phr, input bytes_t pl);
    send_zeros(pre); send_byte(8'hA7); send_byte(phr);
    foreach (pl[i]) send_byte(pl[i]);
  endtask

  task automatic snap(); s0 = n_start; d0 = n_done; e0 = n_err; rx_q.delete(); endtask

  // Frame-level reference: 0 = no sync, 1 = good frame, 2 = length error.
  function automatic int model_kind(input int pre, input logic [7:0] phr);
    int len;
    len = int'(phr[6:0]);
    if (pre < 8) return 0;
    if (len < MIN_LEN || len > 127) return 2;
    return 1;
  endfunction

  task automatic expect_frame(input string tag, input bytes_t pl);
    logic [8:0] got, want;
    check({tag, ".start"}, n_start - s0, 1);
    check({tag, ".len"}, {25'd0, frame_len}, pl.size());
    check({tag, ".done"}, n_done - d0, 1);
    check({tag, ".err"}, n_err - e0, 0);
    check({tag, ".code"}, {29'd0, err_code}, 0);
    check({tag, ".count"}, rx_q.size(), pl.size());
    for (int i = 0; i < pl.size(); i++) begin
      got  = (i < rx_q.size()) ? rx_q[i] : 9'h1FF;
      want = {(i == pl.size() - 1), pl[i]};
      check({tag, ".byte"}, {23'd0, got}, {23'd0, want});
    end
  endtask

`ifdef RX_SEQ_CRC_EN
  function automatic logic [15:0] crc16(input bytes_t d);
    logic [15:0] c;
    logic fb;
    c = 16'd0;
    foreach (d[i]) for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[i][b];
      c = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction
`endif

  initial begin
    bytes_t pl;
    logic [7:0] phr;
    int pre, kind, len;
    logic [15:0] fcs;

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.demod_en", demod_en, 0);
    check("rst.byte_valid", byte_valid, 0);
    check("rst.byte_data", {byte_last, byte_data}, 0);
    check("rst.frame_len", frame_len, 0);
    check("rst.err_code", err_code, 0);
    check("rst.crc_ok", crc_ok, 1);
    check("rst.pulses", {frame_start, frame_done, frame_err}, 0);
    tick();
    reset_n = 1'b1;
    rx_en = 1'b1;
    repeat (3) tick();
    check("wait_lock.busy", busy, 1);
    check("wait_lock.demod_en", demod_en, 1);
    cdr_lock = 1'b1;
    byte_ready = 1'b1;
    repeat (3) tick();

    // Nominal frame, bit every 5 clocks.
    snap();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(32, 8'h05, pl);
    repeat (30) tick();
    expect_frame("ok", pl);
`ifndef RX_SEQ_CRC_EN
    check("ok.crc_ok", crc_ok, 1);
`endif

    // Preamble one zero short, then exactly the minimum.
    snap();
    send_zeros(7); send_byte(8'hA7); send_ones(8);
    repeat (10) tick();
    check("short_pre.start", n_start - s0, 0);
    snap();
    pl = '{8'h5A, 8'hC3, 8'h99};
    send_frame(8, 8'h03, pl);
    repeat (30) tick();
    expect_frame("min_pre", pl);

    // Zero length, then zero length with the ignored MSB set, then recovery.
    snap();
    send_zeros(16); send_byte(8'hA7); send_byte(8'h00); send_ones(8);
    repeat (5) tick();
    check("len0.err", n_err - e0, 1);
    check("len0.code", err_code, 1);
    check("len0.start", n_start - s0, 0);
    snap();
    send_zeros(16); send_byte(8'hA7); send_byte(8'h80); send_ones(8);
    repeat (5) tick();
    check("len80.err", n_err - e0, 1);
    check("len80.code", err_code, 1);
    snap();
    pl = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(12, 8'h04, pl);
    repeat (30) tick();
    expect_frame("after_len_err", pl);

    // Push into a full buffer with a simultaneous pop: no overflow.
    snap();
    byte_ready = 1'b0;
    send_zeros(16); send_byte(8'hA7); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22);
    for (int i = 0; i < 7; i++) send_bit(((8'h33 >> i) & 8'h01) != 0);
    byte_ready = 1'b1;
    send_bit(1'b0);
    send_byte(8'h44);
    repeat (30) tick();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    expect_frame("full_push_pop", pl);

    // Overflow on the third push with no consumer.
    snap();
    byte_ready = 1'b0;
    send_zeros(16); send_byte(8'hA7); send_byte(8'h04);
    send_byte(8'hFF); send_byte(8'hFF);
    tick();
    check("ovf.pre_err", n_err - e0, 0);
    check("ovf.pre_valid", byte_valid, 1);
    send_byte(8'hFF);
    check("ovf.err", n_err - e0, 1);
    check("ovf.code", err_code, 2);
    check("ovf.valid", byte_valid, 0);
    send_byte(8'hFF);
    repeat (5) tick();
    check("ovf.hunt_busy", busy, 1);
    check("ovf.no_done", n_done - d0, 0);
    check("ovf.no_xfer", rx_q.size(), 0);
    byte_ready = 1'b1;

    // Lock loss mid-payload.
    snap();
    send_zeros(16); send_byte(8'hA7); send_byte(8'h06);
    send_byte(8'hAB); send_byte(8'hCD);
    cdr_lock = 1'b0;
    repeat (3) tick();
    check("lock.err", n_err - e0, 1);
    check("lock.code", err_code, 3);
    check("lock.valid", byte_valid, 0);
    check("lock.busy", busy, 1);
    check("lock.demod_en", demod_en, 1);
    snap();
    send_zeros(16); send_byte(8'hA7); send_byte(8'h03);
    check("lock.ignored", n_start - s0, 0);
    cdr_lock = 1'b1;
    repeat (3) tick();

    // Bit stream stalls in PAYLOAD.
    snap();
    send_zeros(16); send_byte(8'hA7); send_byte(8'h05); send_byte(8'h77);
    repeat (TMO - 20) tick();
    check("tmo.early", n_err - e0, 0);
    repeat (40) tick();
    check("tmo.err", n_err - e0, 1);
    check("tmo.code", err_code, 4);
    check("tmo.valid", byte_valid, 0);

    // Randomized streams against the frame-level model.
    rdy_rand = 1'b1;
    gap_lo = 2; gap_hi = 5;
    for (int it = 0; it < 10; it++) begin
      pre = $urandom_range(4, 24);
      len = $urandom_range(0, 6);
      phr = {($urandom_range(0, 1) == 1), 7'(len)};
      kind = model_kind(pre, phr);
      snap();
      pl.delete();
      if (kind == 1) for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
      send_zeros(pre); send_byte(8'hA7);
      if (kind != 0) send_byte(phr);
      foreach (pl[i]) send_byte(pl[i]);
      send_ones(8);
      repeat (60) tick();
      if (kind == 1) expect_frame("rand", pl);
      else if (kind == 2) begin
        check("rand.len_err", n_err - e0, 1);
        check("rand.len_code", err_code, 1);
      end else check("rand.nosync", n_start - s0, 0);
    end
    rdy_rand = 1'b0;
    byte_ready = 1'b1;
    gap_lo = 5; gap_hi = 5;

    // rx_en dropped mid-frame: frame completes, then IDLE.
    snap();
    pl = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    send_zeros(16); send_byte(8'hA7); send_byte(8'h05);
    send_byte(pl[0]); send_byte(pl[1]);
    rx_en = 1'b0;
    send_byte(pl[2]); send_byte(pl[3]); send_byte(pl[4]);
    repeat (20) tick();
    expect_frame("rx_en_drop", pl);
    check("rx_en_drop.busy", busy, 0);
    check("rx_en_drop.demod_en", demod_en, 0);

`ifdef RX_SEQ_CRC_EN
    rx_en = 1'b1;
    repeat (5) tick();
    pl = '{8'h01, 8'h02};
    fcs = crc16(pl);
    pl.push_back(fcs[7:0]); pl.push_back(fcs[15:8]);
    snap();
    send_frame(16, 8'h04, pl);
    repeat (30) tick();
    expect_frame("crc_good", pl);
    check("crc_good.ok", crc_ok, 1);
    pl[1] = pl[1] ^ 8'h04;
    snap();
    send_frame(16, 8'h04, pl);
    repeat (30) tick();
    expect_frame("crc_bad", pl);
    check("crc_bad.ok", crc_ok, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
